// File: rtl/shift_check_if.sv
// rtl/shift_check_if.sv - stimulus/response bundle between a shifter driver and shift_check
interface shift_check_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  localparam int SA_W = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] data;
  logic [SA_W-1:0]  shift_amount;
  logic             right;
  logic             arithmetic;
  logic [WIDTH-1:0] sh_dut;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] check_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output start, data, shift_amount, right, arithmetic, sh_dut,
    input  busy, done, pass, fail, expected, check_count, err_count
  );

  modport slave (
    input  start, data, shift_amount, right, arithmetic, sh_dut,
    output busy, done, pass, fail, expected, check_count, err_count
  );
endinterface

// File: rtl/shift_check.sv
// rtl/shift_check.sv - iterative reference checker for the barrel shifter result
module shift_check #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  shift_check_if.slave bus
);
  localparam int SA_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, CMP} state_t;

  state_t           state;
  logic [SA_W-1:0]  cnt;
  logic             right_q;
  logic             fill_q;
  logic [WIDTH-1:0] sh_q;
  logic             mismatch;

  assign mismatch = (bus.expected != sh_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      right_q         <= 1'b0;
      fill_q          <= 1'b0;
      sh_q            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pass        <= 1'b0;
      bus.fail        <= 1'b0;
      bus.expected    <= '0;
      bus.check_count <= '0;
      bus.err_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.expected <= bus.data;
            cnt          <= bus.shift_amount;
            right_q      <= bus.right;
            // Sign fill only applies to arithmetic right shifts.
            fill_q       <= bus.arithmetic & bus.right & bus.data[WIDTH-1];
            sh_q         <= bus.sh_dut;
            bus.busy     <= 1'b1;
            state        <= (bus.shift_amount != '0) ? SHIFT : CMP;
          end
        end
        SHIFT: begin
          if (right_q)
            bus.expected <= {fill_q, bus.expected[WIDTH-1:1]};
          else
            bus.expected <= {bus.expected[WIDTH-2:0], 1'b0};
          cnt <= cnt - SA_W'(1);
          if (cnt == SA_W'(1))
            state <= CMP;
        end
        CMP: begin
          bus.pass <= !mismatch;
          bus.fail <= mismatch;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          // Counters saturate at all-ones rather than wrapping.
          if (bus.check_count != '1)
            bus.check_count <= bus.check_count + CNT_W'(1);
          if (mismatch && (bus.err_count != '1))
            bus.err_count <= bus.err_count + CNT_W'(1);
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_check.sv
// tb/tb_shift_check.sv - randomized scoreboard bench for shift_check
module tb_shift_check;
  localparam int WIDTH = 32;
  localparam int CNT_W = 10;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] exp;
    logic        pass;
    int          cc;
    int          ec;
    int          due;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   mcc = 0;
  int   mec = 0;
  item_t sb[$];

  shift_check_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_check #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sa,
                                            input logic r, input logic a);
    logic [31:0] e;
    if (!r)     e = d << sa;
    else if (a) e = $signed(d) >>> sa;
    else        e = d >> sa;
    return e;
  endfunction

  task automatic wait_idle();
    int budget = 0;
    while (bus.busy === 1'b1 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (bus.busy !== 1'b0) chk("idle_timeout", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic issue(input logic [31:0] d, input int sa, input logic r,
                       input logic a, input logic [31:0] sh);
    logic [31:0] e;
    wait_idle();
    e = ref_shift(d, sa, r, a);
    if (mcc < MAXC) mcc++;
    if (e != sh && mec < MAXC) mec++;
    sb.push_back('{exp: e, pass: (e == sh), cc: mcc, ec: mec, due: cyc + sa + 2});
    bus.data         = d;
    bus.shift_amount = sa[4:0];
    bus.right        = r;
    bus.arithmetic   = a;
    bus.sh_dut       = sh;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.data         = $urandom;
    bus.sh_dut       = $urandom;
    bus.shift_amount = 5'($urandom);
    bus.right        = 1'($urandom);
    bus.arithmetic   = 1'($urandom);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst && bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          it = sb.pop_front();
          chk("expected", bus.expected, it.exp);
          chk("pass", {31'b0, bus.pass}, {31'b0, it.pass});
          chk("fail", {31'b0, bus.fail}, {31'b0, !it.pass});
          chk("check_count", 32'(bus.check_count), it.cc);
          chk("err_count", 32'(bus.err_count), it.ec);
          chk("done_cycle", cyc, it.due);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] d, e, sh;
    int sa, budget;
    logic r, a;
    bus.start = 1'b0;
    bus.data = '0;
    bus.shift_amount = '0;
    bus.right = 1'b0;
    bus.arithmetic = 1'b0;
    bus.sh_dut = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_expected", bus.expected, 32'd0);
    chk("rst_check_count", 32'(bus.check_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(32'hFF0000FF, 4, 1'b1, 1'b1, 32'hFFF0000F);
    issue(32'hFF0000FF, 8, 1'b1, 1'b0, 32'h00FF0000);
    issue(32'hFF0000FF, 12, 1'b0, 1'b0, 32'h000FF000);
    issue(32'hFF0000FF, 31, 1'b1, 1'b1, 32'hFFFFFFFF);
    issue(32'hFF0000FF, 31, 1'b1, 1'b0, 32'h00000001);
    issue(32'hFF0000FF, 16, 1'b1, 1'b1, 32'h00FFFF00);
    issue(32'h12345678, 0, 1'b0, 1'b0, 32'h12345678);
    issue(32'h80000001, 5, 1'b0, 1'b1, 32'h00000020);

    // start pulsed while busy must be ignored
    issue(32'hA5A5A5A5, 20, 1'b1, 1'b1, 32'hFFFFFA5A);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.data = 32'h0;
    bus.shift_amount = 5'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    @(posedge clk); #1;
    chk("start_ignored_count", 32'(bus.check_count), mcc);

    // reset in the middle of a shift
    issue(32'hDEADBEEF, 25, 1'b0, 1'b0, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_pass", {31'b0, bus.pass}, 32'd0);
    chk("midrst_fail", {31'b0, bus.fail}, 32'd0);
    chk("midrst_check_count", 32'(bus.check_count), 32'd0);
    chk("midrst_err_count", 32'(bus.err_count), 32'd0);
    sb.delete();
    mcc = 0;
    mec = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(32'hFF0000FF, 4, 1'b1, 1'b1, 32'hFFF0000F);

    for (int i = 0; i < 300; i++) begin
      d  = $urandom;
      sa = $urandom_range(0, 31);
      r  = 1'($urandom);
      a  = 1'($urandom);
      e  = ref_shift(d, sa, r, a);
      sh = ($urandom_range(0, 3) == 0) ? (e ^ (32'd1 << $urandom_range(0, 31))) : e;
      issue(d, sa, r, a, sh);
    end

    // drive both counters into saturation
    for (int i = 0; i < MAXC + 10; i++) begin
      d = $urandom;
      issue(d, 0, 1'b0, 1'b0, ~d);
    end

    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("final_check_count", 32'(bus.check_count), MAXC);
    chk("final_err_count", 32'(bus.err_count), MAXC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/shift_check.md
Name: shift_check

Overview:
- Synthesizable response checker for the 32-bit barrel shifter (`shift_mux`), i.e. the receiving end of the shifter's stimulus interface.
- Accepts one operation per `start`: data, amount, right/arithmetic controls and the shifter's result `sh_dut`.
- Computes the expected result iteratively, one bit position per clock, then compares it against the captured result.
- Reports pass/fail and keeps running totals of checks and errors, so benches and on-chip self-test can validate the shifter without a golden model.

Parameters:
- WIDTH, 32, data path width (shift amount width is clog2(WIDTH)).
- CNT_W, 16, width of check and error counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a check; sampled only in IDLE.
- data  input  WIDTH  operand to shift.
- shift_amount  input  5  shift distance, 0..31.
- right  input  1  1 = right shift, 0 = left shift.
- arithmetic  input  1  1 = sign fill on right shift; ignored on left shift.
- sh_dut  input  WIDTH  shifter result under test.
- busy  output  1  high while a check is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- pass  output  1  expected == sh_dut for the last check; held until the next done.
- fail  output  1  mismatch on the last check; held until the next done.
- expected  output  WIDTH  computed reference value; held until the next start.
- check_count  output  CNT_W  completed checks, saturating.
- err_count  output  CNT_W  failed checks, saturating.

Behaviour:
- Reset (async, any time, including mid-check):
  - state = IDLE.
  - busy, done, pass, fail = 0.
  - expected, check_count, err_count = 0.
  - The in-flight check is discarded and not counted.
- FSM states: IDLE, SHIFT, CMP.
- IDLE, start = 1 at edge E0:
  - Capture data into expected, and capture shift_amount into cnt.
  - Capture right, fill bit (arithmetic & right & data[WIDTH-1]) and sh_dut.
  - Next state = SHIFT if shift_amount != 0, else CMP. busy = 1.
  - In IDLE with start = 0: all outputs hold, except done, which is cleared.
- SHIFT, each edge:
  - right = 1: expected = {fill, expected[WIDTH-1:1]}.
  - right = 0: expected = {expected[WIDTH-2:0], 0}.
  - cnt decrements; when cnt == 1 before the edge, next state = CMP.
- CMP, one edge:
  - pass = (expected == captured sh_dut); fail = !pass.
  - done = 1 for exactly one cycle.
  - check_count += 1; err_count += fail. Both stick at all-ones and do not wrap.
  - busy = 0; state = IDLE.
- Latency: done is asserted after edge E(N+1), where N = shift_amount.
  - N = 0 gives 1 cycle; N = 31 gives 32 cycles.
- Back-to-back checks: start may be high in the done cycle and is accepted (state is IDLE).
- start while busy: ignored, with no effect on captured values.
- Inputs are only sampled at E0. Changes to data, sh_dut or the controls during SHIFT/CMP do not affect the check.
- Left shift with arithmetic = 1 is treated as a logical left shift.

Test Plan:
- data = FF0000FF, sa = 4, right = 1, arith = 1, sh_dut = FFF0000F -> done after 5 cycles, expected = FFF0000F, pass = 1, check_count = 1, err_count = 0.
- data = FF0000FF, sa = 8, right = 1, arith = 0, sh_dut = 00FF0000 -> pass = 1. Then sa = 12, right = 0, sh_dut = 000FF000 -> pass = 1, check_count = 2.
- data = FF0000FF, sa = 31, right = 1, arith = 1, sh_dut = FFFFFFFF -> done after 32 cycles, pass. Repeat with arith = 0, sh_dut = 00000001 -> pass.
- Injected error: sa = 16, right = 1, arith = 1, sh_dut = 00FFFF00 (correct is FFFFFF00) -> fail = 1, pass = 0, err_count increments, expected = FFFFFF00.
- sa = 0, sh_dut = data -> done one cycle after start, pass. start pulsed during a 20-cycle check -> ignored, check_count rises by 1 only.
- rst asserted mid-SHIFT -> busy, done, pass, fail, counters immediately 0. A following check completes normally with check_count = 1. 65536 checks -> check_count stays FFFF.
